// File: rtl/seq_addsub.sv
// Sequential add/subtract. Operands are consumed CHUNK bits per clock, LSB slice
// first, with a registered carry/borrow chain between slices.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cb_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out,
  output logic             cb_out,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;

  logic             r_mode, r_chain;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [CW-1:0]    r_cnt;
  logic [CHUNK:0]   w_sl;
  logic [WIDTH-1:0] w_res;
  logic             w_accept, w_last, w_ovf;

  assign busy     = (r_state == RUN);
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = busy && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands shift right each cycle, so the active slice is always the low CHUNK
  // bits; on the last cycle the low slice holds the operand sign bits.
  always_comb begin
    if (r_mode)
      w_sl = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_chain};
    else
      w_sl = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]} - {{CHUNK{1'b0}}, r_chain};
    w_res = (r_acc >> CHUNK) | (WIDTH'(w_sl[CHUNK-1:0]) << (WIDTH - CHUNK));
    w_ovf = (r_mode ? (r_a[CHUNK-1] == r_b[CHUNK-1]) : (r_a[CHUNK-1] != r_b[CHUNK-1]))
            && (w_sl[CHUNK-1] != r_a[CHUNK-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= 1'b0;
      r_chain <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      done    <= 1'b0;
      d_out   <= '0;
      cb_out  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_mode  <= mode;
        r_a     <= a_in;
        r_b     <= b_in;
        r_chain <= cb_in;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (busy) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_chain <= w_sl[CHUNK];
        r_acc   <= w_res;
        r_cnt   <= r_cnt + CW'(1);
        // Visible outputs change only when the full result is assembled.
        if (w_last) begin
          d_out  <= w_res;
          cb_out <= w_sl[CHUNK];
          ovf    <= w_ovf;
          done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: three configurations (8/4, 8/1, 4/4), directed corner
// cases plus a scoreboard-checked back-to-back stream per configuration.
module tb_seq_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, mode, cb_in;
  logic [1:0] sel;
  logic [7:0] a8, b8;
  logic       st84, st81, st44;
  logic       busy84, done84, cbo84, ovf84;
  logic       busy81, done81, cbo81, ovf81;
  logic       busy44, done44, cbo44, ovf44;
  logic [7:0] d84, d81;
  logic [3:0] d44;
  logic       done_s;
  logic [9:0] res_s;

  int errs = 0;
  int checks = 0;
  logic [9:0] q[$];

  localparam logic       TM [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [7:0] TA [4] = '{8'h00, 8'h80, 8'h7F, 8'hFF};
  localparam logic [7:0] TB [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
  localparam logic       TC [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] ED [4] = '{8'hFF, 8'h7F, 8'h80, 8'h00};
  localparam logic       EC [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic       EO [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  assign st84 = start && (sel == 2'd0);
  assign st81 = start && (sel == 2'd1);
  assign st44 = start && (sel == 2'd2);

  seq_addsub #(.WIDTH(8), .CHUNK(4)) u84 (
    .clk(clk), .rst(rst), .start(st84), .mode(mode), .a_in(a8), .b_in(b8),
    .cb_in(cb_in), .busy(busy84), .done(done84), .d_out(d84), .cb_out(cbo84), .ovf(ovf84));
  seq_addsub #(.WIDTH(8), .CHUNK(1)) u81 (
    .clk(clk), .rst(rst), .start(st81), .mode(mode), .a_in(a8), .b_in(b8),
    .cb_in(cb_in), .busy(busy81), .done(done81), .d_out(d81), .cb_out(cbo81), .ovf(ovf81));
  seq_addsub #(.WIDTH(4), .CHUNK(4)) u44 (
    .clk(clk), .rst(rst), .start(st44), .mode(mode), .a_in(a8[3:0]), .b_in(b8[3:0]),
    .cb_in(cb_in), .busy(busy44), .done(done44), .d_out(d44), .cb_out(cbo44), .ovf(ovf44));

  always_comb begin
    case (sel)
      2'd0:    begin done_s = done84; res_s = {ovf84, cbo84, d84}; end
      2'd1:    begin done_s = done81; res_s = {ovf81, cbo81, d81}; end
      default: begin done_s = done44; res_s = {ovf44, cbo44, 4'h0, d44}; end
    endcase
  end

  // Full-width reference; result packed as {ovf, cb_out, d_out} (4-bit d zero-extended).
  function automatic logic [9:0] gold(input int s, input logic m, input logic [7:0] a,
                                      input logic [7:0] b, input logic c);
    logic [8:0] r;
    logic [4:0] r4;
    logic ov;
    if (s != 2) begin
      r  = m ? ({1'b0, a} + {1'b0, b} + {8'h0, c}) : ({1'b0, a} - {1'b0, b} - {8'h0, c});
      ov = m ? ((a[7] == b[7]) && (r[7] != a[7])) : ((a[7] != b[7]) && (r[7] != a[7]));
      return {ov, r};
    end
    r4 = m ? ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, c})
           : ({1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, c});
    ov = m ? ((a[3] == b[3]) && (r4[3] != a[3])) : ((a[3] != b[3]) && (r4[3] != a[3]));
    return {ov, r4[4], 4'h0, r4[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({busy84, done84, cbo84, ovf84, d84} !== 12'h0) begin
      errs++; $display("FAIL reset_84: got %h want 000", {busy84, done84, cbo84, ovf84, d84});
    end
    checks++;
    if ({busy81, done81, cbo81, ovf81, d81} !== 12'h0) begin
      errs++; $display("FAIL reset_81: got %h want 000", {busy81, done81, cbo81, ovf81, d81});
    end
    checks++;
    if ({busy44, done44, cbo44, ovf44, d44} !== 8'h0) begin
      errs++; $display("FAIL reset_44: got %h want 00", {busy44, done44, cbo44, ovf44, d44});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [7:0] last_d;
    last_d = 8'h00;
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      mode = TM[i]; a8 = TA[i]; b8 = TB[i]; cb_in = TC[i]; start = 1'b1;
      step();
      start = 1'b0;
      mode = ~mode; a8 = 8'($urandom); b8 = 8'($urandom); cb_in = ~cb_in;
      checks++;
      if ({busy84, done84} !== 2'b10) begin
        errs++; $display("FAIL dir%0d_t0: busy/done got %b want 10", i, {busy84, done84});
      end
      step();
      checks++;
      if ({busy84, done84, d84} !== {2'b10, last_d}) begin
        errs++; $display("FAIL dir%0d_t1: busy/done/d got %h want %h", i, {busy84, done84, d84}, {2'b10, last_d});
      end
      step();
      checks++;
      if ({busy84, done84, ovf84, cbo84, d84} !== {2'b01, EO[i], EC[i], ED[i]}) begin
        errs++; $display("FAIL dir%0d_res: busy/done/ovf/cb/d got %h want %h", i,
                         {busy84, done84, ovf84, cbo84, d84}, {2'b01, EO[i], EC[i], ED[i]});
      end
      step();
      checks++;
      if ({done84, d84} !== {1'b0, ED[i]}) begin
        errs++; $display("FAIL dir%0d_hold: done/d got %h want %h", i, {done84, d84}, {1'b0, ED[i]});
      end
      last_d = ED[i];
    end
  endtask

  task automatic test_busy_ignore();
    sel = 2'd0;
    mode = 1'b0; a8 = 8'h10; b8 = 8'h01; cb_in = 1'b0; start = 1'b1;
    step();
    mode = 1'b1; a8 = 8'h55; b8 = 8'h55;
    step();
    start = 1'b0;
    step();
    checks++;
    if ({done84, ovf84, cbo84, d84} !== {3'b100, 8'h0F}) begin
      errs++; $display("FAIL busy_ignore_res: done/ovf/cb/d got %h want %h", {done84, ovf84, cbo84, d84}, {3'b100, 8'h0F});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy84, done84, d84} !== {2'b00, 8'h0F}) begin
        errs++; $display("FAIL busy_ignore_idle%0d: busy/done/d got %h want 00f", i, {busy84, done84, d84});
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    sel = 2'd0;
    mode = 1'b0; a8 = 8'h33; b8 = 8'h11; cb_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy84, done84, ovf84, cbo84, d84} !== 12'h0) begin
      errs++; $display("FAIL abort_async: busy/done/ovf/cb/d got %h want 000", {busy84, done84, ovf84, cbo84, d84});
    end
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done84 || busy84) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL abort_no_done: activity got %b want 0", seen);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if ({done84, ovf84, cbo84, d84} !== {3'b100, 8'h22}) begin
      errs++; $display("FAIL abort_restart: done/ovf/cb/d got %h want %h", {done84, ovf84, cbo84, d84}, {3'b100, 8'h22});
    end
  endtask

  // Back-to-back ops: each new start is raised in the done cycle of the previous one.
  task automatic test_stream(input int s, input bit exh, input int nops);
    int lat, gap;
    logic [9:0] e;
    lat = (s == 0) ? 3 : (s == 1) ? 9 : 2;
    sel = 2'(s);
    for (int n = 0; n < nops; n++) begin
      if (exh) begin
        mode = n[9]; cb_in = n[8]; a8 = {4'h0, n[7:4]}; b8 = {4'h0, n[3:0]};
      end else begin
        mode = 1'($urandom); cb_in = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      end
      q.push_back(gold(s, mode, a8, b8, cb_in));
      start = 1'b1;
      gap = 0;
      do begin
        step();
        start = 1'b0;
        mode = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        gap++;
      end while (!done_s && gap < 40);
      checks++;
      if (gap != lat) begin
        errs++; $display("FAIL stream%0d_lat op%0d: got %0d want %0d", s, n, gap, lat);
      end
      e = q.pop_front();
      checks++;
      if (res_s !== e) begin
        errs++; $display("FAIL stream%0d_res op%0d: {ovf,cb,d} got %h want %h", s, n, res_s, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 2'd0; mode = 1'b0; cb_in = 1'b0; a8 = 8'h0; b8 = 8'h0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_stream(0, 1'b0, 1500);
    test_stream(1, 1'b0, 600);
    test_stream(2, 1'b1, 1024);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
